// File: rtl/dram_pkg.sv
// Shared types and field widths for the DRAM command scheduler.
package dram_pkg;

  localparam int BANK_GROUP_BITS = 2;
  localparam int BANK_BITS       = 2;
  localparam int ROW_BITS        = 14;
  localparam int COLUMN_BITS     = 10;
  localparam int BANK_IDX_BITS   = BANK_GROUP_BITS + BANK_BITS;
  localparam int NUM_BANKS       = 2 ** (BANK_GROUP_BITS + BANK_BITS);
  localparam int CNT_BITS        = 16;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_PREA = 3'd5,
    CMD_REF  = 3'd6
  } cmd_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_PRE_WAIT,
    ST_ACT,
    ST_ACT_WAIT,
    ST_RW,
    ST_PREA,
    ST_PREA_WAIT,
    ST_REF,
    ST_REF_WAIT
  } sched_state_t;

  // Flat table index of a bank: bank group is the upper part.
  function automatic logic [BANK_IDX_BITS-1:0] bank_index(
    input logic [BANK_GROUP_BITS-1:0] bg,
    input logic [BANK_BITS-1:0]       bank
  );
    return {bg, bank};
  endfunction

endpackage

// File: rtl/dram_cmd_scheduler_open_row_table.sv
// Open-row tracker: one valid bit and row address per bank.
module open_row_table
  import dram_pkg::*;
(
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [BANK_IDX_BITS-1:0] lookup_idx,
  input  logic [ROW_BITS-1:0]      lookup_row,
  input  logic                     set,
  input  logic [BANK_IDX_BITS-1:0] set_idx,
  input  logic [ROW_BITS-1:0]      set_row,
  input  logic                     clear,
  input  logic [BANK_IDX_BITS-1:0] clear_idx,
  input  logic                     clear_all,
  output logic                     hit,
  output logic                     open,
  output logic                     any_open
);

  logic [NUM_BANKS-1:0] valid_q;
  logic [ROW_BITS-1:0]  row_q [NUM_BANKS];

  // Table update; precharge-all wins over any single-bank set/clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else begin
      if (set) begin
        valid_q[set_idx] <= 1'b1;
        row_q[set_idx]   <= set_row;
      end
      if (clear) valid_q[clear_idx] <= 1'b0;
    end
  end

  // Combinational lookup for the request being offered.
  always_comb begin
    open     = valid_q[lookup_idx];
    hit      = valid_q[lookup_idx] && (row_q[lookup_idx] == lookup_row);
    any_open = |valid_q;
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Single-rank DRAM command scheduler: PRE/ACT/RD/WR with tRP/tRCD, refresh via PREA+REF.
//
// state        | meaning
// IDLE         | waiting; refresh has priority over new requests
// PRE          | precharge target bank (one cycle)
// PRE_WAIT     | tRP spacing after PRE
// ACT          | activate target row (one cycle)
// ACT_WAIT     | tRCD spacing after ACT
// RW           | issue RD or WR, pulse done
// PREA         | precharge all banks before refresh
// PREA_WAIT    | tRP spacing after PREA
// REF          | refresh command
// REF_WAIT     | tRFC spacing, ref_ack on last cycle
module dram_cmd_scheduler
  import dram_pkg::*;
#(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RFC = 16
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [BANK_GROUP_BITS-1:0] req_BG,
  input  logic [BANK_BITS-1:0]       req_bank,
  input  logic [ROW_BITS-1:0]        req_row,
  input  logic [COLUMN_BITS-1:0]     req_col,
  input  logic                       ref_req,
  output logic                       ref_ack,
  output logic                       cmd_valid,
  output cmd_t                       cmd,
  output logic [BANK_GROUP_BITS-1:0] cmd_BG,
  output logic [BANK_BITS-1:0]       cmd_bank,
  output logic [ROW_BITS-1:0]        cmd_row,
  output logic [COLUMN_BITS-1:0]     cmd_col,
  output logic                       done,
  output logic                       row_hit
);

  localparam logic [CNT_BITS-1:0] RCD_LOAD = CNT_BITS'(T_RCD - 2);
  localparam logic [CNT_BITS-1:0] RP_LOAD  = CNT_BITS'(T_RP - 2);
  localparam logic [CNT_BITS-1:0] RFC_LOAD = CNT_BITS'(T_RFC - 2);

  sched_state_t state, state_next;
  logic [CNT_BITS-1:0] cnt, cnt_next;

  logic                       write_q;
  logic [BANK_GROUP_BITS-1:0] bg_q;
  logic [BANK_BITS-1:0]       bank_q;
  logic [ROW_BITS-1:0]        row_q;
  logic [COLUMN_BITS-1:0]     col_q;

  logic accept;
  logic tbl_hit, tbl_open, tbl_any_open;
  logic tbl_set, tbl_clear, tbl_clear_all;

  assign accept = (state == ST_IDLE) && !ref_req && req_valid;

  open_row_table u_table (
    .CLK        (CLK),
    .nRST       (nRST),
    .lookup_idx (bank_index(req_BG, req_bank)),
    .lookup_row (req_row),
    .set        (tbl_set),
    .set_idx    (bank_index(bg_q, bank_q)),
    .set_row    (row_q),
    .clear      (tbl_clear),
    .clear_idx  (bank_index(bg_q, bank_q)),
    .clear_all  (tbl_clear_all),
    .hit        (tbl_hit),
    .open       (tbl_open),
    .any_open   (tbl_any_open)
  );

  // State and wait counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the accepted request and whether it hit an open row.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      write_q <= 1'b0;
      bg_q    <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      row_hit <= 1'b0;
    end else if (accept) begin
      write_q <= req_write;
      bg_q    <= req_BG;
      bank_q  <= req_bank;
      row_q   <= req_row;
      col_q   <= req_col;
      row_hit <= tbl_hit;
    end
  end

  // Next state, counter load/decrement and per-state command outputs.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    req_ready     = 1'b0;
    cmd_valid     = 1'b0;
    cmd           = CMD_NOP;
    done          = 1'b0;
    ref_ack       = 1'b0;
    tbl_set       = 1'b0;
    tbl_clear     = 1'b0;
    tbl_clear_all = 1'b0;
    cmd_BG        = '0;
    cmd_bank      = '0;
    cmd_row       = '0;
    cmd_col       = '0;
    if (state == ST_PRE || state == ST_ACT || state == ST_RW) begin
      cmd_BG   = bg_q;
      cmd_bank = bank_q;
      cmd_row  = row_q;
      cmd_col  = col_q;
    end
    case (state)
      ST_IDLE: begin
        if (ref_req) begin
          state_next = tbl_any_open ? ST_PREA : ST_REF;
        end else begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (tbl_hit)       state_next = ST_RW;
            else if (tbl_open) state_next = ST_PRE;
            else               state_next = ST_ACT;
          end
        end
      end
      ST_PRE: begin
        cmd_valid  = 1'b1;
        cmd        = CMD_PRE;
        tbl_clear  = 1'b1;
        cnt_next   = RP_LOAD;
        state_next = ST_PRE_WAIT;
      end
      ST_PRE_WAIT: begin
        if (cnt == '0) state_next = ST_ACT;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_ACT: begin
        cmd_valid  = 1'b1;
        cmd        = CMD_ACT;
        tbl_set    = 1'b1;
        cnt_next   = RCD_LOAD;
        state_next = ST_ACT_WAIT;
      end
      ST_ACT_WAIT: begin
        if (cnt == '0) state_next = ST_RW;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_RW: begin
        cmd_valid  = 1'b1;
        cmd        = write_q ? CMD_WR : CMD_RD;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_PREA: begin
        cmd_valid     = 1'b1;
        cmd           = CMD_PREA;
        tbl_clear_all = 1'b1;
        cnt_next      = RP_LOAD;
        state_next    = ST_PREA_WAIT;
      end
      ST_PREA_WAIT: begin
        if (cnt == '0) state_next = ST_REF;
        else           cnt_next   = cnt - 1'b1;
      end
      ST_REF: begin
        cmd_valid  = 1'b1;
        cmd        = CMD_REF;
        cnt_next   = RFC_LOAD;
        state_next = ST_REF_WAIT;
      end
      ST_REF_WAIT: begin
        if (cnt == '0) begin
          ref_ack    = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Self-checking bench: command scoreboard plus table-driven request vectors.
module tb_dram_cmd_scheduler;
  import dram_pkg::*;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RFC = 16;
  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_CONF = 2;

  logic                       CLK = 1'b0;
  logic                       nRST = 1'b0;
  logic                       req_valid = 1'b0;
  logic                       req_ready;
  logic                       req_write = 1'b0;
  logic [BANK_GROUP_BITS-1:0] req_BG = '0;
  logic [BANK_BITS-1:0]       req_bank = '0;
  logic [ROW_BITS-1:0]        req_row = '0;
  logic [COLUMN_BITS-1:0]     req_col = '0;
  logic                       ref_req = 1'b0;
  logic                       ref_ack;
  logic                       cmd_valid;
  cmd_t                       cmd;
  logic [BANK_GROUP_BITS-1:0] cmd_BG;
  logic [BANK_BITS-1:0]       cmd_bank;
  logic [ROW_BITS-1:0]        cmd_row;
  logic [COLUMN_BITS-1:0]     cmd_col;
  logic                       done;
  logic                       row_hit;

  always #5 CLK = ~CLK;

  dram_cmd_scheduler #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_BG(req_BG), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .cmd_valid(cmd_valid), .cmd(cmd),
    .cmd_BG(cmd_BG), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .done(done), .row_hit(row_hit)
  );

  typedef struct {
    int                         cyc;
    cmd_t                       c;
    logic [BANK_GROUP_BITS-1:0] bg;
    logic [BANK_BITS-1:0]       bank;
    logic [ROW_BITS-1:0]        row;
    logic [COLUMN_BITS-1:0]     col;
  } exp_t;

  typedef struct {
    logic                       w;
    logic [BANK_GROUP_BITS-1:0] bg;
    logic [BANK_BITS-1:0]       bank;
    logic [ROW_BITS-1:0]        row;
    logic [COLUMN_BITS-1:0]     col;
    int                         kind;
  } vec_t;

  exp_t exp_q[$];
  int   ack_q[$];
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   any_open_m = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Scoreboard: every issued command must match the head of the expected queue.
  always @(negedge CLK) begin
    if (nRST) begin
      if (cmd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_cmd at cycle %0d: got %0d, expected none", cyc, cmd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cmd_cycle", 32'(cyc), 32'(e.cyc));
          check("cmd", 32'(cmd), 32'(e.c));
          check("cmd_BG", 32'(cmd_BG), 32'(e.bg));
          check("cmd_bank", 32'(cmd_bank), 32'(e.bank));
          check("cmd_row", 32'(cmd_row), 32'(e.row));
          check("cmd_col", 32'(cmd_col), 32'(e.col));
          check("done", 32'(done), 32'(e.c == CMD_RD || e.c == CMD_WR));
        end
      end else begin
        check("idle_cmd", 32'(cmd), 32'(CMD_NOP));
        check("idle_done", 32'(done), 32'd0);
      end
      if (ref_ack) begin
        if (ack_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ref_ack at cycle %0d: got 1, expected 0", cyc);
        end else begin
          check("ref_ack_cycle", 32'(cyc), 32'(ack_q.pop_front()));
        end
      end
    end
  end

  function automatic void push_cmd(input int at, input cmd_t c, input logic [BANK_GROUP_BITS-1:0] bg,
                                   input logic [BANK_BITS-1:0] bank, input logic [ROW_BITS-1:0] row,
                                   input logic [COLUMN_BITS-1:0] col);
    exp_t e;
    e.cyc = at; e.c = c; e.bg = bg; e.bank = bank; e.row = row; e.col = col;
    exp_q.push_back(e);
  endfunction

  // Expected refresh sequence when IDLE sees ref_req in cycle t.
  function automatic void push_refresh(input int t);
    if (any_open_m) begin
      push_cmd(t + 1, CMD_PREA, '0, '0, '0, '0);
      push_cmd(t + 1 + T_RP, CMD_REF, '0, '0, '0, '0);
      ack_q.push_back(t + T_RP + T_RFC);
    end else begin
      push_cmd(t + 1, CMD_REF, '0, '0, '0, '0);
      ack_q.push_back(t + T_RFC);
    end
    any_open_m = 1'b0;
  endfunction

  task automatic issue(input logic w, input logic [BANK_GROUP_BITS-1:0] bg, input logic [BANK_BITS-1:0] bank,
                       input logic [ROW_BITS-1:0] row, input logic [COLUMN_BITS-1:0] col,
                       input int kind, output int t);
    int   n;
    cmd_t rw;
    @(negedge CLK);
    req_write = w; req_BG = bg; req_bank = bank; req_row = row; req_col = col;
    req_valid = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout at cycle %0d: req_ready 0, expected 1", cyc);
      req_valid = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    rw = w ? CMD_WR : CMD_RD;
    case (kind)
      K_HIT: push_cmd(t + 1, rw, bg, bank, row, col);
      K_MISS: begin
        push_cmd(t + 1, CMD_ACT, bg, bank, row, col);
        push_cmd(t + 1 + T_RCD, rw, bg, bank, row, col);
      end
      default: begin
        push_cmd(t + 1, CMD_PRE, bg, bank, row, col);
        push_cmd(t + 1 + T_RP, CMD_ACT, bg, bank, row, col);
        push_cmd(t + 1 + T_RP + T_RCD, rw, bg, bank, row, col);
      end
    endcase
    any_open_m = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    check("row_hit", 32'(row_hit), 32'(kind == K_HIT));
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!ref_ack && n < 500) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!ref_ack) begin
      checks++;
      fails++;
      $display("FAIL ref_ack_timeout at cycle %0d: ref_ack 0, expected 1", cyc);
    end
    ref_req = 1'b0;
  endtask

  vec_t vecs[10];
  int   t, t0, t_idle;

  initial begin
    vecs[0] = '{1'b0, 2'd2, 2'd3, 14'h0100, 10'h003, K_MISS};
    vecs[1] = '{1'b1, 2'd2, 2'd3, 14'h0100, 10'h007, K_HIT};
    vecs[2] = '{1'b0, 2'd0, 2'd1, 14'h0020, 10'h009, K_HIT};
    vecs[3] = '{1'b1, 2'd3, 2'd0, 14'h3FFF, 10'h3FF, K_MISS};
    vecs[4] = '{1'b0, 2'd3, 2'd0, 14'h0000, 10'h000, K_CONF};
    vecs[5] = '{1'b0, 2'd2, 2'd3, 14'h0101, 10'h001, K_CONF};
    vecs[6] = '{1'b1, 2'd0, 2'd0, 14'h0000, 10'h000, K_MISS};
    vecs[7] = '{1'b0, 2'd0, 2'd0, 14'h0000, 10'h001, K_HIT};
    vecs[8] = '{1'b1, 2'd3, 2'd3, 14'h3FFF, 10'h000, K_MISS};
    vecs[9] = '{1'b0, 2'd3, 2'd3, 14'h3FFF, 10'h3FF, K_HIT};

    // Reset values.
    repeat (3) @(negedge CLK);
    check("rst_cmd", 32'(cmd), 32'(CMD_NOP));
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ref_ack", 32'(ref_ack), 32'd0);
    check("rst_row_hit", 32'(row_hit), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_fields", 32'({cmd_BG, cmd_bank, cmd_row, cmd_col}), 32'd0);
    nRST = 1'b1;

    // Closed bank, then hit, then conflict on the same bank.
    issue(1'b0, 2'd0, 2'd1, 14'h0010, 10'h008, K_MISS, t0);
    issue(1'b0, 2'd0, 2'd1, 14'h0010, 10'h018, K_HIT, t);
    check("b2b_accept_cycle", 32'(t), 32'(t0 + 1 + T_RCD + 1));
    issue(1'b1, 2'd0, 2'd1, 14'h0020, 10'h004, K_CONF, t);

    for (int i = 0; i < 10; i++)
      issue(vecs[i].w, vecs[i].bg, vecs[i].bank, vecs[i].row, vecs[i].col, vecs[i].kind, t);

    // Refresh and request together in IDLE with banks open: refresh first.
    repeat (12) @(negedge CLK);
    ref_req = 1'b1;
    req_write = 1'b0; req_BG = 2'd1; req_bank = 2'd2; req_row = 14'h0055; req_col = 10'h002;
    req_valid = 1'b1;
    #1;
    check("ready_during_ref", 32'(req_ready), 32'd0);
    t0 = cyc;
    push_refresh(t0);
    wait_ack();
    issue(1'b0, 2'd1, 2'd2, 14'h0055, 10'h002, K_MISS, t);
    check("accept_after_ref", 32'(t), 32'(t0 + T_RP + T_RFC + 1));

    // Refresh rising during ACT_WAIT does not disturb the in-flight read.
    issue(1'b0, 2'd0, 2'd3, 14'h0007, 10'h011, K_MISS, t);
    @(negedge CLK);
    #1 ref_req = 1'b1;
    t_idle = t + 1 + T_RCD + 1;
    push_refresh(t_idle);
    while (cyc < t_idle) @(negedge CLK);
    #1;
    check("ready_idle_ref", 32'(req_ready), 32'd0);
    wait_ack();

    // Refresh with every bank closed goes straight to REF.
    repeat (3) @(negedge CLK);
    #1 ref_req = 1'b1;
    push_refresh(cyc);
    wait_ack();

    // Reset in ACT_WAIT drops the request and empties the table.
    issue(1'b1, 2'd2, 2'd1, 14'h0033, 10'h005, K_MISS, t);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    check("midrst_cmd", 32'(cmd), 32'(CMD_NOP));
    check("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    ack_q.delete();
    any_open_m = 1'b0;
    @(negedge CLK);
    #1 nRST = 1'b1;
    issue(1'b1, 2'd2, 2'd1, 14'h0033, 10'h005, K_MISS, t);
    issue(1'b0, 2'd2, 2'd1, 14'h0033, 10'h006, K_HIT, t);

    repeat (12) @(negedge CLK);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d: simulation did not finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Single-rank DRAM command scheduler that sits downstream of the address mapper. It accepts one decoded request at a time (bank group, bank, row, column, read/write) and tracks the open row of every bank. It issues the minimal legal DDR command sequence (PRE/ACT/RD/WR) with tRP/tRCD spacing, and services refresh requests with precharge-all plus REF.

## Interface
Parameters:
- T_RCD, 4, ACT-to-RD/WR spacing in cycles (must be >= 2)
- T_RP, 4, PRE/PREA-to-next-command spacing in cycles (must be >= 2)
- T_RFC, 16, REF-to-ref_ack spacing in cycles (must be >= 2)

Ports (field widths from dram_pkg: BANK_GROUP_BITS, BANK_BITS, ROW_BITS, COLUMN_BITS):
- CLK  in  1  clock, all state on rising edge
- nRST  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept
- req_write  in  1  1 = WR, 0 = RD
- req_BG / req_bank / req_row / req_col  in  field widths  decoded address from address mapper
- ref_req  in  1  refresh request level, held until ref_ack
- ref_ack  out  1  one-cycle pulse when refresh completes
- cmd_valid  out  1  command issued this cycle
- cmd  out  cmd_t  issued command
- cmd_BG / cmd_bank / cmd_row / cmd_col  out  field widths  command address
- done  out  1  pulse in the cycle RD/WR issues
- row_hit  out  1  last accepted request hit an open row

## Operation
- States: IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, RW, PREA, PREA_WAIT, REF, REF_WAIT.
- Command states (PRE, ACT, RW, PREA, REF) last exactly one cycle with cmd_valid=1. Every other state drives cmd=CMD_NOP and cmd_valid=0.
- req_ready=1 only in IDLE with ref_req=0. On accept, the request fields are registered and the next state is chosen from the open-row table entry of {req_BG,req_bank}:
  - valid and row equal → RW (row_hit=1)
  - valid and row different → PRE
  - invalid → ACT
- Flow: PRE→PRE_WAIT→ACT; ACT→ACT_WAIT→RW; RW→IDLE. RW issues CMD_WR or CMD_RD with done=1.
- Refresh has priority in IDLE. If ref_req=1: any bank open → PREA, else → REF. Then PREA→PREA_WAIT→REF→REF_WAIT→IDLE, with ref_ack pulsed in the final REF_WAIT cycle.
- Refresh never aborts an accepted request; it is serviced on the next IDLE.
- Open-row table: one valid bit plus row per bank, NUM_BANKS entries.
  - ACT sets valid and row.
  - PRE clears the target bank.
  - PREA clears all banks.
  - RD/WR and REF leave the table unchanged.
- cmd_BG/cmd_bank/cmd_row/cmd_col come from the registered request. They are 0 for PREA/REF.

## Timing
- Wait counter: loaded with T_x-2 on the command cycle, decremented each wait cycle; the wait state exits when the counter is 0. A wait state therefore lasts T_x-1 cycles, so a dependent command issues exactly T_x cycles after its predecessor.
- Latency from accept cycle t:
  - hit: RD/WR at t+1
  - closed bank: ACT t+1, RD/WR t+1+T_RCD
  - conflict: PRE t+1, ACT t+1+T_RP, RD/WR t+1+T_RP+T_RCD
- Back-to-back requests: the next accept occurs at the earliest in the cycle after RW.
- Refresh from IDLE at t with banks open: PREA t+1, REF t+1+T_RP, ref_ack t+T_RP+T_RFC, then IDLE.
- row_hit is registered at accept and holds until the next accept.
- Reset values: state IDLE, table all invalid, cmd=CMD_NOP, cmd_valid=0, done=0, ref_ack=0, row_hit=0, all cmd_* fields 0, counter 0.
- req_ready is 1 after reset unless ref_req is asserted.
- Reset mid-operation immediately returns to IDLE and drops the in-flight request.

## Structure
- dram_pkg: add the cmd_t enum (3 bits: CMD_NOP=0, CMD_ACT=1, CMD_PRE=2, CMD_RD=3, CMD_WR=4, CMD_PREA=5, CMD_REF=6) and NUM_BANKS = 2**(BANK_GROUP_BITS+BANK_BITS).
- Define the scheduler state enum in the package.
- Sub-module open_row_table:
  - inputs: lookup index, set (index, row), clear (index), clear_all
  - outputs: hit, open
  - clear_all takes priority over set/clear.

## Test plan
- Reset: nRST low mid-ACT_WAIT → next edge shows IDLE, cmd=CMD_NOP, req_ready=1, all table entries invalid.
- Closed bank: read BG0/bank1 row 0x10 col 0x8 accepted at cycle 0 → CMD_ACT row 0x10 at 1, CMD_RD col 0x8 with done at 5, row_hit=0.
- Hit: read BG0/bank1 row 0x10 col 0x18 accepted at cycle 6 → CMD_RD at 7, done at 7, row_hit=1, no ACT.
- Conflict: write BG0/bank1 row 0x20 accepted at 0 → CMD_PRE at 1, CMD_ACT row 0x20 at 5, CMD_WR at 9; table entry bank1 = row 0x20.
- Refresh vs request: ref_req and req_valid both high in IDLE at 0 with one bank open → req_ready=0; CMD_PREA at 1, CMD_REF at 5, ref_ack at 20. Request accepted at 21 as a closed-bank miss (ACT at 22).
- Refresh during a request: ref_req rises in ACT_WAIT → RD still issues on schedule, then PREA follows in the cycle after the next IDLE.
